// File: rtl/fifo_reader_pkg.sv
// Shared constants for the FIFO stream reader: occupancy width, packet counter width, buffer depth.
// The optional m_tlast generation is enabled with the FIFO_READER_LAST_EN macro.
package fifo_reader_pkg;
  localparam int unsigned OCC_W     = 2;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned BUF_DEPTH = 3;
endpackage

// File: rtl/fifo_reader_buf.sv
// Three-entry ordered skid buffer with occupancy count; head word is always at entry 0.
// Used by fifo_stream_reader (FIFO_READER_LAST_EN has no effect here).
module fifo_reader_buf
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [DW-1:0]    wdata,
  input  logic             rd,
  output logic [DW-1:0]    rdata,
  output logic [OCC_W-1:0] occ
);

  logic [DW-1:0]    mem_q [BUF_DEPTH];
  logic [DW-1:0]    mem_d [BUF_DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [OCC_W-1:0] wr_idx;

  // Pop shifts the queue toward the head; the write lands after the last surviving entry.
  always_comb begin
    mem_d  = mem_q;
    occ_d  = occ_q;
    wr_idx = occ_q;
    if (rd && (occ_q != '0)) begin
      mem_d[0] = mem_q[1];
      mem_d[1] = mem_q[2];
      wr_idx   = occ_q - OCC_W'(1);
      occ_d    = wr_idx;
    end
    if (wr && (wr_idx < OCC_W'(BUF_DEPTH))) begin
      mem_d[wr_idx] = wdata;
      occ_d         = wr_idx + OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
    mem_q <= mem_d;
  end

  assign rdata = mem_q[0];
  assign occ   = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a source FIFO read port into an AXI-Stream style master through a 3-word buffer.
// Define FIFO_READER_LAST_EN to generate m_tlast every PKT_LEN transfers; otherwise m_tlast is 0.
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned FWFT    = 0,
  parameter int unsigned PKT_LEN = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] fifo_dout,
  input  logic          fifo_empty,
  output logic          fifo_re,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast
);

  logic [OCC_W-1:0] occ;
  logic             infl_q, infl_d;
  logic             buf_wr;
  logic             xfer;

  assign xfer = m_tvalid && m_tready;

  // Pop only when the buffer can absorb every word already requested; m_tready is not involved.
  always_comb begin
    fifo_re = !fifo_empty && !rst && ((3'(occ) + 3'(infl_q)) <= 3'd2);
    infl_d  = (FWFT == 0) ? fifo_re : 1'b0;
    buf_wr  = (FWFT == 0) ? infl_q : fifo_re;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      infl_q <= 1'b0;
    end else begin
      infl_q <= infl_d;
    end
  end

  fifo_reader_buf #(.DW(DW)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .wr    (buf_wr),
    .wdata (fifo_dout),
    .rd    (xfer),
    .rdata (m_tdata),
    .occ   (occ)
  );

  assign m_tvalid = (occ != '0);

`ifdef FIFO_READER_LAST_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_last;

  assign cnt_last = (cnt_q == CNT_W'(PKT_LEN - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (xfer) begin
      cnt_d = cnt_last ? '0 : (cnt_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign m_tlast = m_tvalid && cnt_last;
`else
  assign m_tlast = 1'b0;
`endif

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter DW, default 8: data width in bits.
REQ-002 Parameter FWFT, default 0: 1 = source FIFO is first-word-fall-through, 0 = dout valid one cycle after re.
REQ-003 Parameter PKT_LEN, default 16: words per packet for m_tlast, range 1..65535.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 fifo_dout  in  DW  read data from the source FIFO read port.
REQ-007 fifo_empty  in  1  source FIFO empty flag.
REQ-008 fifo_re  out  1  source FIFO pop strobe.
REQ-009 m_tdata  out  DW  stream data.
REQ-010 m_tvalid  out  1  stream valid.
REQ-011 m_tready  in  1  stream ready from the sink.
REQ-012 m_tlast  out  1  last word of packet; tied 0 without FIFO_READER_LAST_EN.

Function
REQ-013 A transfer occurs on each cycle with m_tvalid and m_tready both high.
REQ-014 The internal buffer holds 3 words in order; occ is its occupancy (0..3), and infl (0..1) marks a non-FWFT read awaiting data.
REQ-015 fifo_re = !fifo_empty && !rst && (occ + infl <= 2), using registered occ/infl only; no combinational path from m_tready to fifo_re.
REQ-016 FWFT=0: fifo_dout is written to the buffer on the cycle after fifo_re; infl = registered fifo_re.
REQ-017 FWFT=1: fifo_dout is written to the buffer on the same cycle fifo_re is high; infl stays 0.
REQ-018 m_tvalid = (occ != 0); m_tdata = buffer head; both driven from registers.
REQ-019 A simultaneous write and transfer leaves occ unchanged and preserves order.
REQ-020 Sustained throughput is 1 word/clk when the FIFO is non-empty and m_tready is held high.
REQ-021 First-word latency from fifo_empty falling to m_tvalid rising is 2 cycles for FWFT=0 and 1 cycle for FWFT=1.
REQ-022 m_tdata and m_tvalid hold stable while m_tvalid=1 and m_tready=0.
REQ-023 The buffer never overflows; occ=3 blocks fifo_re.
REQ-024 fifo_empty rising while infl=1 still accepts the in-flight word.

Reset
REQ-025 On rst, the following clear on the next edge: occ=0, infl=0, m_tvalid=0, m_tlast=0, packet counter=0.
REQ-026 fifo_re=0 during rst.
REQ-027 An in-flight word at reset is discarded; the source FIFO is reset together with this block.
REQ-028 m_tdata content is don't-care while m_tvalid=0.

Configuration
REQ-029 Macro FIFO_READER_LAST_EN defined: a 16-bit packet counter counts transfers, and m_tlast=1 on the head word when counter==PKT_LEN-1.
REQ-030 With FIFO_READER_LAST_EN, the counter wraps to 0 after the transfer with m_tlast=1.
REQ-031 With FIFO_READER_LAST_EN, m_tlast is registered alongside the head word.
REQ-032 FIFO_READER_LAST_EN undefined: no counter logic; m_tlast is constant 0.

Structure
REQ-033 Occupancy width (2 bits) and packet counter width (16 bits) are constants in the shared package fifo_reader_pkg.
REQ-034 The 3-entry ordered buffer with occupancy count is sub-module fifo_reader_buf (ports: clk, rst, wr, wdata, rd, rdata, occ).
REQ-035 Top level holds only the fifo_re decision, the infl register and the optional packet counter.

Verification
REQ-036 FWFT=0, FIFO preloaded 0x01..0x08, m_tready=1 -> m_tvalid at cycle 2 after reset release, 0x01..0x08 on 8 consecutive cycles.
REQ-037 FWFT=1, same stimulus -> m_tvalid at cycle 1, identical data sequence, no gaps.
REQ-038 m_tready=0 for 10 cycles with FIFO full -> exactly 3 pops, occ=3, m_tdata=0x01 held; m_tready=1 -> 0x01,0x02,0x03,... in order, none lost or duplicated.
REQ-039 FIFO_READER_LAST_EN, PKT_LEN=4, 12 words with random m_tready -> m_tlast high on words 4, 8 and 12 only.
REQ-040 rst asserted mid-stream with occ=2, infl=1 -> next cycle m_tvalid=0, fifo_re=0; after FIFO refill 0xA0.. the first output is 0xA0.
REQ-041 fifo_empty toggling every cycle with random m_tready over 1000 words -> output matches the scoreboard exactly.
